median_linebuf_ctrl: RTL and testbench
======================================

Name: median_linebuf_ctrl

Overview:
Controller and sequencer for the 1920x64 dual-port line-buffer SRAM used by the disparity median filter. It accepts a raster stream of left/right disparity pairs and drives the SRAM write and read ports, including the active-low enables and bit-write mask. It packs the two previous rows into each 64-bit word. For every accepted pixel it emits a 3-row vertical column (top/mid/bot) for L and R, plus position and border flags, to the downstream 3x3 sorter.

Parameters:
WIDTH, 16, bits per disparity sample; SRAM word = 4*WIDTH (64 at default)
MAX_COLS, 1920, SRAM depth; column counter range
ADDR_W, 11, SRAM address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
clken  in  1  global pipeline enable; low = full stall
width  in  11  active columns per row, legal range 3..MAX_COLS
sof  in  1  start of frame; qualifies the pixel presented with valid_in
valid_in  in  1  pixel pair valid
disp_L  in  WIDTH  left disparity
disp_R  in  WIDTH  right disparity
wr_en_n  out  1  SRAM port A write enable, active-low
bweb  out  4*WIDTH  SRAM port A bit write mask, active-low
wr_addr  out  ADDR_W  SRAM port A address
wr_data  out  4*WIDTH  SRAM port A data
rd_en_n  out  1  SRAM port B read enable, active-low
rd_addr  out  ADDR_W  SRAM port B address
rd_data  in  4*WIDTH  SRAM port B data, 1-cycle latency
win_L_top, win_L_mid, win_L_bot  out  WIDTH each  L column rows r-2, r-1, r
win_R_top, win_R_mid, win_R_bot  out  WIDTH each  R column rows r-2, r-1, r
col_first  out  1  window column is col 0
col_last  out  1  window column is width-1
row_top  out  1  window row < 2 (upper rows not yet valid)
valid_out  out  1  window outputs valid

Behaviour:
- Reset (rst=0 at clk edge): col=0, row=0, both pipeline stages invalid; wr_en_n=1, rd_en_n=1, bweb all-ones; all window outputs 0; flags 0; valid_out=0. Reset mid-frame discards in-flight pixels. SRAM contents are not cleared.
- Word layout: [4W-1:3W]=L(r-1), [3W-1:2W]=R(r-1), [2W-1:W]=L(r-2), [W-1:0]=R(r-2).
- Stage 0, cycle t (valid_in & clken): rd_en_n=0, rd_addr=col. Pixel, col, row and flags are registered into stage 1.
  - Then col increments.
  - At col==width_q-1, col wraps to 0 and row increments, saturating at 2047.
- sof & valid_in: the pixel is treated as col 0, row 0 regardless of counters. width is latched into width_q on every accepted pixel at col 0.
- Stage 1, cycle t+1: wr_en_n=0, wr_addr=stage-1 col, bweb=0, wr_data={L,R,rd_data[4W-1:2W]}.
- Window registers load at t+1: top=rd_data L(r-2)/R(r-2), mid=L(r-1)/R(r-1), bot=current pixel. valid_out=1 at t+2 (latency 2).
- The write trails the read by one column, so a same-address read/write never occurs for width>=3. width<3 is illegal: the counter still wraps at width_q, and outputs are unspecified.
- Stall (clken=0): counters and stages frozen; wr_en_n=1, rd_en_n=1, outputs held.
  - The read port stays idle, so rd_data holds across the stall. Stage 1 is completed on the first clken=1 cycle after the stall.
- Bubbles (valid_in=0, clken=1): no read. A stage-1 write still completes. valid_out drops one cycle after the bubble enters stage 1.
- Flag timing: col_first/col_last/row_top are computed at stage 0 and travel with the pixel.
- row_top: without the optional feature, top/mid outputs are forced to 0 while row_top applies to that row: row 0 zeroes top and mid, row 1 zeroes top.

Optional Feature:
MEDIAN_LB_REPLICATE_EN:
- Defined: rows 0..1 use replicated top/mid instead of zeros. Row 0: top=mid=bot. Row 1: top=mid (from rd_data L(r-1)/R(r-1)).
- Row-0 SRAM writes store the current pixel in both row slots, wr_data={L,R,L,R}.
- Not defined: zero-fill as described above, and row-0 wr_data lower half = rd_data upper half (stale).

Test Plan:
- Reset mid-frame (rst=0 one cycle during row 1) -> next cycle wr_en_n=1, rd_en_n=1, bweb=all-ones, valid_out=0; following sof restarts at col 0/row 0.
- width=4, three rows of L=10*row+col, R=100+L -> at row 2 col 1, valid_out two cycles after input with L top/mid/bot = 1/11/21, R = 101/111/121. col_first=1 on col 0 only, col_last=1 on col 3 only.
- Same stream, SRAM port check -> row 1 col 2: rd_addr=2 at t, wr_addr=2 at t+1, wr_data={12,112,2,102}, bweb=0.
- clken=0 for 5 cycles between col 1 and col 2 -> no enables asserted during stall; outputs held; resumed window identical to the unstalled run.
- valid_in gaps of 3 cycles every pixel, width=1920 -> col wraps at 1919, row increments once per row, no duplicate or lost columns.
- Rows 0/1 top-border handling -> row 0: without macro top=mid=0; with MEDIAN_LB_REPLICATE_EN top=mid=bot and wr_data={L,R,L,R}.

Source files
------------

// File: rtl/median_linebuf_ctrl.sv
// Line-buffer SRAM sequencer: packs two previous rows per word and emits 3-row L/R columns to the median sorter.
// Optional build macro MEDIAN_LB_REPLICATE_EN replicates border rows instead of zero-filling them.
module median_linebuf_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_COLS = 1920,
    parameter int ADDR_W   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken,
    input  logic [ADDR_W-1:0]    width,
    input  logic                 sof,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     disp_L,
    input  logic [WIDTH-1:0]     disp_R,
    output logic                 wr_en_n,
    output logic [4*WIDTH-1:0]   bweb,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [4*WIDTH-1:0]   wr_data,
    output logic                 rd_en_n,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [4*WIDTH-1:0]   rd_data,
    output logic [WIDTH-1:0]     win_L_top,
    output logic [WIDTH-1:0]     win_L_mid,
    output logic [WIDTH-1:0]     win_L_bot,
    output logic [WIDTH-1:0]     win_R_top,
    output logic [WIDTH-1:0]     win_R_mid,
    output logic [WIDTH-1:0]     win_R_bot,
    output logic                 col_first,
    output logic                 col_last,
    output logic                 row_top,
    output logic                 valid_out
);
    localparam int ROW_W = 11;
    localparam int DW    = 4*WIDTH;

    function automatic logic [ROW_W-1:0] f_row_inc(input logic [ROW_W-1:0] r);
        return (r == '1) ? r : r + 1'b1;
    endfunction

    logic [ADDR_W-1:0]  r_col, r_width_q, r_col_p1;
    logic [ROW_W-1:0]   r_row;
    logic               r_vld_p1, r_row0_p1, r_row1_p1, r_first_p1, r_last_p1;
    logic [WIDTH-1:0]   r_L_p1, r_R_p1;
    logic [ADDR_W-1:0]  w_col_p0, w_width_p0;
    logic [ROW_W-1:0]   w_row_p0;
    logic               w_accept_p0, w_first_p0, w_last_p0, w_wr_p1;
    logic [WIDTH-1:0]   w_top_L, w_mid_L, w_top_R, w_mid_R;
    logic [2*WIDTH-1:0] w_lower_p1;

    // Stage 0: position of the incoming pixel; sof overrides the counters
    assign w_accept_p0 = valid_in & clken;
    assign w_col_p0    = sof ? '0 : r_col;
    assign w_row_p0    = sof ? '0 : r_row;
    assign w_first_p0  = (w_col_p0 == '0);
    assign w_width_p0  = w_first_p0 ? width : r_width_q;
    assign w_last_p0   = (w_col_p0 == w_width_p0 - 1'b1);

    assign rd_en_n = ~w_accept_p0;
    assign rd_addr = w_col_p0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_width_q <= ADDR_W'(MAX_COLS);
            r_vld_p1  <= 1'b0;
        end else if (clken) begin
            r_vld_p1 <= valid_in;
            if (valid_in) begin
                if (w_first_p0) r_width_q <= width;
                if (w_last_p0) begin
                    r_col <= '0;
                    r_row <= f_row_inc(w_row_p0);
                end else begin
                    r_col <= w_col_p0 + 1'b1;
                    r_row <= w_row_p0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept_p0) begin
            r_L_p1     <= disp_L;
            r_R_p1     <= disp_R;
            r_col_p1   <= w_col_p0;
            r_row0_p1  <= (w_row_p0 == '0);
            r_row1_p1  <= (w_row_p0 == ROW_W'(1));
            r_first_p1 <= w_first_p0;
            r_last_p1  <= w_last_p0;
        end
    end

    // Stage 1: write back current pixel plus the row it displaces one column behind the read
    assign w_wr_p1 = r_vld_p1 & clken;
    assign wr_en_n = ~w_wr_p1;
    assign wr_addr = r_col_p1;
    assign bweb    = w_wr_p1 ? '0 : '1;
`ifdef MEDIAN_LB_REPLICATE_EN
    assign w_lower_p1 = r_row0_p1 ? {r_L_p1, r_R_p1} : rd_data[DW-1:2*WIDTH];
`else
    assign w_lower_p1 = rd_data[DW-1:2*WIDTH];
`endif
    assign wr_data = {r_L_p1, r_R_p1, w_lower_p1};

    always_comb begin
        w_top_L = rd_data[2*WIDTH-1:WIDTH];
        w_top_R = rd_data[WIDTH-1:0];
        w_mid_L = rd_data[DW-1:3*WIDTH];
        w_mid_R = rd_data[3*WIDTH-1:2*WIDTH];
`ifdef MEDIAN_LB_REPLICATE_EN
        if (r_row0_p1) begin
            w_top_L = r_L_p1;
            w_top_R = r_R_p1;
            w_mid_L = r_L_p1;
            w_mid_R = r_R_p1;
        end else if (r_row1_p1) begin
            w_top_L = rd_data[DW-1:3*WIDTH];
            w_top_R = rd_data[3*WIDTH-1:2*WIDTH];
        end
`else
        if (r_row0_p1) begin
            w_top_L = '0;
            w_top_R = '0;
            w_mid_L = '0;
            w_mid_R = '0;
        end else if (r_row1_p1) begin
            w_top_L = '0;
            w_top_R = '0;
        end
`endif
    end

    // Stage 2: registered window towards the sorter
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_out <= 1'b0;
            win_L_top <= '0;
            win_L_mid <= '0;
            win_L_bot <= '0;
            win_R_top <= '0;
            win_R_mid <= '0;
            win_R_bot <= '0;
            col_first <= 1'b0;
            col_last  <= 1'b0;
            row_top   <= 1'b0;
        end else if (clken) begin
            valid_out <= r_vld_p1;
            if (r_vld_p1) begin
                win_L_top <= w_top_L;
                win_L_mid <= w_mid_L;
                win_L_bot <= r_L_p1;
                win_R_top <= w_top_R;
                win_R_mid <= w_mid_R;
                win_R_bot <= r_R_p1;
                col_first <= r_first_p1;
                col_last  <= r_last_p1;
                row_top   <= r_row0_p1 | r_row1_p1;
            end
        end
    end
endmodule

// File: tb/tb_median_linebuf_ctrl.sv
// Scoreboard bench for median_linebuf_ctrl with a behavioural frame model and an SRAM model.
`timescale 1ns/1ps
module tb_median_linebuf_ctrl;
    localparam int W  = 16;
    localparam int MC = 1920;
    localparam int AW = 11;
`ifdef MEDIAN_LB_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] lt, lm, lb, rt, rm, rb;
        logic         first, last, rtop;
    } win_t;
    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [4*W-1:0] data;
        logic [4*W-1:0] mask;
    } wr_t;

    logic clk = 1'b0, rst = 1'b0, clken = 1'b0, sof = 1'b0, valid_in = 1'b0;
    logic [AW-1:0]  width = AW'(4);
    logic [W-1:0]   disp_L = '0, disp_R = '0;
    logic           wr_en_n, rd_en_n, valid_out, col_first, col_last, row_top;
    logic [4*W-1:0] bweb, wr_data, rd_data;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [W-1:0]   win_L_top, win_L_mid, win_L_bot, win_R_top, win_R_mid, win_R_bot;

    median_linebuf_ctrl #(.WIDTH(W), .MAX_COLS(MC), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .clken(clken), .width(width), .sof(sof),
        .valid_in(valid_in), .disp_L(disp_L), .disp_R(disp_R),
        .wr_en_n(wr_en_n), .bweb(bweb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_n(rd_en_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .win_L_top(win_L_top), .win_L_mid(win_L_mid), .win_L_bot(win_L_bot),
        .win_R_top(win_R_top), .win_R_mid(win_R_mid), .win_R_bot(win_R_bot),
        .col_first(col_first), .col_last(col_last), .row_top(row_top),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    // SRAM model: 1-cycle read latency, read data held while idle
    logic [4*W-1:0] mem [MC];
    initial rd_data = '0;
    always @(posedge clk) begin
        if (!wr_en_n) mem[wr_addr] <= wr_data;
        if (!rd_en_n) rd_data <= mem[rd_addr];
    end

    int n_chk = 0, n_fail = 0;
    win_t q_win[$];
    wr_t  q_wr[$];
    logic [AW-1:0] q_rd[$];
    logic ce_last = 1'b0;
    win_t last_exp = '0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endfunction

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    // Reference frame model: last three rows of pixels by column
    int m_col = 0, m_row = 0, m_wq = MC;
    logic [W-1:0] pl [3][MC];
    logic [W-1:0] pr [3][MC];

    task automatic accept_model(input bit s, input logic [W-1:0] L, input logic [W-1:0] R);
        int c, r;
        win_t e;
        wr_t  wx;
        c = s ? 0 : m_col;
        r = s ? 0 : m_row;
        if (c == 0) m_wq = int'(width);
        e.lb = L;
        e.rb = R;
        if (r >= 1) begin
            e.lm = pl[(r-1)%3][c];
            e.rm = pr[(r-1)%3][c];
        end else begin
            e.lm = REP ? L : '0;
            e.rm = REP ? R : '0;
        end
        if (r >= 2) begin
            e.lt = pl[(r-2)%3][c];
            e.rt = pr[(r-2)%3][c];
        end else begin
            e.lt = REP ? e.lm : '0;
            e.rt = REP ? e.rm : '0;
        end
        e.first = (c == 0);
        e.last  = (c == m_wq - 1);
        e.rtop  = (r < 2);
        q_win.push_back(e);
        wx.addr = AW'(c);
        if (r >= 1) wx.data = {L, R, pl[(r-1)%3][c], pr[(r-1)%3][c]};
        else        wx.data = {L, R, L, R};
        wx.mask = (r == 0 && !REP) ? {{2*W{1'b1}}, {2*W{1'b0}}} : {4*W{1'b1}};
        q_wr.push_back(wx);
        pl[r%3][c] = L;
        pr[r%3][c] = R;
        if (c == m_wq - 1) begin
            m_col = 0;
            m_row = (r < 2047) ? r + 1 : r;
        end else begin
            m_col = c + 1;
            m_row = r;
        end
    endtask

    task automatic cyc(input bit s, input bit v, input bit ce, input logic [W-1:0] L, input logic [W-1:0] R);
        sof = s; valid_in = v; clken = ce; disp_L = L; disp_R = R;
        if (v && ce) q_rd.push_back(AW'(s ? 0 : m_col));
        @(posedge clk);
        if (v && ce && rst) accept_model(s, L, R);
        #1;
    endtask

    task automatic do_reset();
        win_t a;
        rst = 1'b0; sof = 1'b0; valid_in = 1'b0; clken = 1'b1;
        @(posedge clk);
        #1;
        q_win.delete(); q_wr.delete(); q_rd.delete();
        m_col = 0; m_row = 0;
        a = {win_L_top, win_L_mid, win_L_bot, win_R_top, win_R_mid, win_R_bot, col_first, col_last, row_top};
        check("rst_wr_en_n", 128'(wr_en_n), 128'(1));
        check("rst_rd_en_n", 128'(rd_en_n), 128'(1));
        check("rst_bweb", 128'(bweb), 128'({4*W{1'b1}}));
        check("rst_valid_out", 128'(valid_out), 128'(0));
        check("rst_window", 128'(a), 128'(0));
        rst = 1'b1;
    endtask

    task automatic frame(input int w, input int npix, input bit formula, input bit use_sof,
                         input int gap, input int stall_pct, input int stall_idx);
        width = AW'(w);
        for (int i = 0; i < npix; i++) begin
            int r, c, g;
            logic [W-1:0] L, R;
            r = i / w;
            c = i % w;
            if (formula) begin
                L = W'(10*r + c);
                R = W'(100 + 10*r + c);
            end else begin
                L = rnd();
                R = rnd();
            end
            if (i == stall_idx) repeat (5) cyc(1'b0, 1'b1, 1'b0, L, R);
            else if (int'($urandom_range(99)) < stall_pct)
                repeat ($urandom_range(3, 1)) cyc(1'b0, 1'($urandom_range(1)), 1'b0, rnd(), rnd());
            cyc(use_sof && i == 0, 1'b1, 1'b1, L, R);
            g = (gap < 0) ? int'($urandom_range(2)) : gap;
            repeat (g) cyc(1'b0, 1'b0, 1'b1, rnd(), rnd());
        end
    endtask

    always @(posedge clk) ce_last <= clken;

    // Monitor: SRAM port checks and window scoreboard
    always @(negedge clk) begin
        win_t a, e;
        wr_t  we;
        if (!clken) begin
            check("stall_wr_en_n", 128'(wr_en_n), 128'(1));
            check("stall_rd_en_n", 128'(rd_en_n), 128'(1));
        end
        if (!rd_en_n) begin
            if (q_rd.size() == 0) fail("rd_unexpected");
            else check("rd_addr", 128'(rd_addr), 128'(q_rd.pop_front()));
        end
        if (!wr_en_n) begin
            if (q_wr.size() == 0) fail("wr_unexpected");
            else begin
                we = q_wr.pop_front();
                check("wr_addr", 128'(wr_addr), 128'(we.addr));
                check("wr_data", 128'(wr_data & we.mask), 128'(we.data & we.mask));
                check("bweb_write", 128'(bweb), 128'(0));
            end
        end else begin
            check("bweb_idle", 128'(bweb), 128'({4*W{1'b1}}));
        end
        if (valid_out) begin
            a = {win_L_top, win_L_mid, win_L_bot, win_R_top, win_R_mid, win_R_bot, col_first, col_last, row_top};
            if (ce_last) begin
                if (q_win.size() == 0) fail("window_unexpected");
                else begin
                    e = q_win.pop_front();
                    last_exp = e;
                    check("window", 128'(a), 128'(e));
                end
            end else begin
                check("window_hold", 128'(a), 128'(last_exp));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        frame(4, 12, 1'b1, 1'b1, 0, 0, -1);
        frame(4, 12, 1'b1, 1'b1, 0, 0, 6);
        frame(5, 7, 1'b0, 1'b1, -1, 0, -1);
        do_reset();
        frame(5, 25, 1'b0, 1'b0, 1, 20, -1);
        frame(3, 12, 1'b0, 1'b1, 0, 30, -1);
        frame(6, 24, 1'b0, 1'b1, -1, 25, -1);
        frame(MC, 2*MC + 5, 1'b0, 1'b1, 3, 0, -1);
        for (int k = 0; k < 10 && (q_win.size() + q_wr.size() + q_rd.size()) != 0; k++)
            cyc(1'b0, 1'b0, 1'b1, '0, '0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, '0, '0);
        check("pending_windows", 128'(q_win.size()), 128'(0));
        check("pending_writes", 128'(q_wr.size()), 128'(0));
        check("pending_reads", 128'(q_rd.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
